// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: tracks in-flight writers in EX/MEM/WB and drives stall/flush/freeze controls.
// Optional feature macro: HAZARD_CTL_FORWARDING_EN (load-use-only stalls when a forwarding network exists).
module hazard_ctl (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        pipe_hold,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } slot_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STALL  = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } state_t;

  localparam int SLOT_EX  = 0;
  localparam int SLOT_MEM = 1;
  localparam int SLOT_WB  = 2;

  slot_t       sb_q [3];
  slot_t       sb_d [3];
  state_t      state_q;
  state_t      state_d;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;
  logic        hazard;

  // x0 is hardwired, so a writer of x0 never creates a dependency.
  function automatic logic slot_hit(input slot_t s, input logic [4:0] rs1, input logic [4:0] rs2);
    return s.valid && s.reg_write && (s.rd != 5'd0) && ((s.rd == rs1) || (s.rd == rs2));
  endfunction

  always_comb begin : hazard_detect
`ifdef HAZARD_CTL_FORWARDING_EN
    hazard = id_valid && slot_hit(sb_q[SLOT_EX], id_rs1, id_rs2) && sb_q[SLOT_EX].mem_read;
`else
    hazard = id_valid && (slot_hit(sb_q[SLOT_EX], id_rs1, id_rs2) ||
                          slot_hit(sb_q[SLOT_MEM], id_rs1, id_rs2));
`endif
  end

  always_comb begin : decide
    state_d      = ST_RUN;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;
    if (mem_busy)          state_d = ST_FREEZE;
    else if (branch_taken) state_d = ST_FLUSH;
    else if (hazard)       state_d = ST_STALL;
    case (state_d)
      ST_FREEZE: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_hold   = 1'b1;
      end
      ST_FLUSH: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      ST_STALL: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin : next_scoreboard
    for (int i = 0; i < 3; i++) sb_d[i] = sb_q[i];
    if (!mem_busy) begin
      sb_d[SLOT_WB]  = sb_q[SLOT_MEM];
      sb_d[SLOT_MEM] = sb_q[SLOT_EX];
      sb_d[SLOT_EX]  = '0;
      if (id_valid && !id_ex_bubble)
        sb_d[SLOT_EX] = {1'b1, id_rd, id_reg_write, id_mem_read};
    end
    stall_cnt_d = stall_cnt_q;
    if ((state_d == ST_STALL) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) sb_q[i] <= '0;
      state_q     <= ST_RUN;
      stall_cnt_q <= 16'd0;
    end else begin
      for (int i = 0; i < 3; i++) sb_q[i] <= sb_d[i];
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: reset-time vector table, hand-written hazard sequences and random
// traffic checked against a queue-of-in-flight-instructions reference model.
module tb_hazard_ctl;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        branch_taken;
  logic        mem_busy;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        pipe_hold;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  hazard_ctl dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .pipe_hold(pipe_hold), .state(state), .stall_cnt(stall_cnt)
  );

  // clock / reset
  always #5 clock = ~clock;

`ifdef HAZARD_CTL_FORWARDING_EN
  localparam int   LU_STALLS = 1;
  localparam logic WR_MR     = 1'b1;
`else
  localparam int   LU_STALLS = 2;
  localparam logic WR_MR     = 1'b0;
`endif

  localparam logic [4:0] C_RUN    = 5'b11000;
  localparam logic [4:0] C_STALL  = 5'b00010;
  localparam logic [4:0] C_FLUSH  = 5'b11110;
  localparam logic [4:0] C_FREEZE = 5'b00001;

  int checks   = 0;
  int failures = 0;

  // reference model: list of issued instructions with their age (0=EX, 1=MEM, 2=WB)
  typedef struct {
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    int         age;
  } inflight_t;

  inflight_t   fl_q[$];
  logic [1:0]  m_state;
  logic [15:0] m_cnt;
  logic [22:0] exp_q[$];

  logic [4:0]  c_o;
  logic [1:0]  s_o;
  logic [15:0] n_o;
  logic [15:0] base;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
    logic       busy;
    logic [4:0] ctl;
  } vec_t;

  vec_t tbl[6];

  function automatic logic m_hazard();
    logic hit;
    if (!id_valid) return 1'b0;
    foreach (fl_q[i]) begin
      hit = fl_q[i].rw && (fl_q[i].rd != 5'd0) && ((fl_q[i].rd == id_rs1) || (fl_q[i].rd == id_rs2));
`ifdef HAZARD_CTL_FORWARDING_EN
      if (hit && (fl_q[i].age == 0) && fl_q[i].mr) return 1'b1;
`else
      if (hit && (fl_q[i].age <= 1)) return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_decide();
    if (mem_busy)     return 2'd3;
    if (branch_taken) return 2'd2;
    if (m_hazard())   return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [4:0] m_ctl(input logic [1:0] d);
    case (d)
      2'd1:    return C_STALL;
      2'd2:    return C_FLUSH;
      2'd3:    return C_FREEZE;
      default: return C_RUN;
    endcase
  endfunction

  task automatic model_reset();
    fl_q.delete();
    m_state = 2'd0;
    m_cnt   = 16'd0;
  endtask

  task automatic model_step();
    logic [1:0] d;
    logic [4:0] ctl;
    inflight_t  e;
    inflight_t  nq[$];
    d   = m_decide();
    ctl = m_ctl(d);
    m_state = d;
    if ((d == 2'd1) && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
    if (!mem_busy) begin
      foreach (fl_q[i]) begin
        if (fl_q[i].age < 2) begin
          e = fl_q[i];
          e.age = e.age + 1;
          nq.push_back(e);
        end
      end
      if (id_valid && !ctl[1]) begin
        e.rd = id_rd; e.rw = id_reg_write; e.mr = id_mem_read; e.age = 0;
        nq.push_back(e);
      end
      fl_q = nq;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: model expectation pushed, popped and compared against the sampled outputs
  task automatic sample_and_check();
    logic [22:0] e;
    exp_q.push_back({m_ctl(m_decide()), m_state, m_cnt});
    e   = exp_q.pop_front();
    c_o = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold};
    s_o = state;
    n_o = stall_cnt;
    check("model_ctl", 16'(c_o), 16'(e[22:18]));
    check("model_state", 16'(s_o), 16'(e[17:16]));
    check("model_cnt", n_o, e[15:0]);
  endtask

  // driver
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic br, input logic busy);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_mem_read = mr; branch_taken = br; mem_busy = busy;
  endtask

  task automatic cycle(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic br, input logic busy);
    @(negedge clock);
    drive(v, rs1, rs2, rd, rw, mr, br, busy);
    #1;
    sample_and_check();
    @(posedge clock);
    model_step();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();

    tbl[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN};
    tbl[1] = '{1'b1, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, C_RUN};
    tbl[2] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_FLUSH};
    tbl[3] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, C_FREEZE};
    tbl[4] = '{1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, C_FREEZE};
    tbl[5] = '{1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, C_FLUSH};

    repeat (2) @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      drive(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rw, tbl[i].mr, tbl[i].br, tbl[i].busy);
      #1;
      check("rst_ctl", 16'({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}), 16'(tbl[i].ctl));
      check("rst_state", 16'(state), 16'd0);
      check("rst_cnt", stall_cnt, 16'd0);
    end
    @(negedge clock);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // writer of x5 then a consumer of x5
    base = m_cnt;
    cycle(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, WR_MR, 1'b0, 1'b0);
    check("a_writer_run", 16'(c_o), 16'(C_RUN));
    for (int k = 0; k < LU_STALLS; k++) begin
      cycle(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      check("a_stall", 16'(c_o), 16'(C_STALL));
    end
    cycle(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("a_issue", 16'(c_o), 16'(C_RUN));
    idle(1);
    check("a_cnt", n_o, 16'(base + 16'(LU_STALLS)));
    idle(3);

    // branch taken together with a load-use hazard
    base = m_cnt;
    cycle(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    check("b_flush", 16'(c_o), 16'(C_FLUSH));
    idle(1);
    check("b_state", 16'(s_o), 16'd2);
    check("b_cnt", n_o, base);
    idle(3);

    // memory freeze while a stall is pending
    base = m_cnt;
    cycle(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, WR_MR, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
      check("c_freeze", 16'(c_o), 16'(C_FREEZE));
      check("c_cnt_hold", n_o, base);
    end
    for (int k = 0; k < LU_STALLS; k++) begin
      cycle(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      check("c_resume_stall", 16'(c_o), 16'(C_STALL));
      if (k == 0) check("c_state_freeze", 16'(s_o), 16'd3);
    end
    cycle(1'b1, 5'd5, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("c_issue", 16'(c_o), 16'(C_RUN));
    idle(1);
    check("c_cnt", n_o, 16'(base + 16'(LU_STALLS)));
    idle(3);

    // load to x0 followed by uses of x0
    cycle(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    check("d_x0_run", 16'(c_o), 16'(C_RUN));
    cycle(1'b1, 5'd0, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    check("d_x0_run2", 16'(c_o), 16'(C_RUN));
    idle(3);

    // counter saturation from a preloaded value
    @(negedge clock);
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 16'hFFFE;
    cycle(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j <= LU_STALLS; j++)
        cycle(1'b1, 5'(5 + k), 5'd0, 5'(6 + k), 1'b1, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clock);
    drive(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    sample_and_check();
    check("e_sat_cnt", n_o, 16'hFFFF);
    check("e_pre_reset_stall", 16'(c_o), 16'(C_STALL));
    // asynchronous reset in the middle of a stall
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    sample_and_check();
    check("e_rst_ctl", 16'(c_o), 16'(C_RUN));
    check("e_rst_state", 16'(s_o), 16'd0);
    check("e_rst_cnt", n_o, 16'd0);
    @(negedge clock);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 The block SHALL have input clock, 1 bit: rising-edge clock.
REQ-002 The block SHALL have input reset, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have inputs id_valid (1), id_rs1 (5), id_rs2 (5), id_rd (5), id_reg_write (1) and id_mem_read (1): the decoded instruction currently in ID.
REQ-004 The block SHALL have input branch_taken, 1 bit: a branch in EX resolved taken this cycle.
REQ-005 The block SHALL have input mem_busy, 1 bit: the data memory is not ready and the pipeline must freeze.
REQ-006 The block SHALL have outputs pc_write (1), if_id_write (1), if_id_flush (1), id_ex_bubble (1) and pipe_hold (1): pipeline register controls.
REQ-007 The block SHALL have output state, 2 bits: RUN=0, STALL=1, FLUSH=2, FREEZE=3.
REQ-008 The block SHALL have output stall_cnt, 16 bits: count of hazard-stall cycles.

Function
REQ-009 The block SHALL keep a scoreboard of three slots, EX, MEM and WB, each holding {valid, rd, reg_write, mem_read}.
REQ-010 On each clock edge with mem_busy=0, the scoreboard SHALL shift WB<=MEM and MEM<=EX.
REQ-011 On the same edge, EX SHALL load the ID fields when id_valid=1 and id_ex_bubble=0; otherwise EX SHALL load an invalid slot.
REQ-012 When mem_busy=1, all scoreboard slots SHALL hold their values.
REQ-013 A slot SHALL match a source register when slot.valid=1, slot.reg_write=1, slot.rd!=0 and slot.rd equals id_rs1 or id_rs2.
REQ-014 A hazard SHALL be raised only when id_valid=1; sources equal to x0 SHALL never match.
REQ-015 The hazard condition SHALL depend on FORWARDING_EN as defined in REQ-027 and REQ-028.
REQ-016 Controls SHALL be combinational, applying the first matching priority: mem_busy, then branch_taken, then hazard, then none.
REQ-017 In FREEZE (mem_busy=1): pc_write=0, if_id_write=0, pipe_hold=1, id_ex_bubble=0, if_id_flush=0.
REQ-018 In FLUSH (branch_taken=1): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, pipe_hold=0; a simultaneous hazard SHALL be ignored.
REQ-019 In STALL (hazard): pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, pipe_hold=0.
REQ-020 In RUN: pc_write=1, if_id_write=1, and all other controls are 0.
REQ-021 The state output SHALL be a register that captures the priority decision of the current cycle at each clock edge, so it lags the controls by one cycle.
REQ-022 stall_cnt SHALL increment by 1 on each clock edge where the STALL decision applies.
REQ-023 stall_cnt SHALL saturate at 0xFFFF and never wrap.

Reset
REQ-024 While reset=1, all scoreboard slots SHALL be invalid, state=RUN and stall_cnt=0.
REQ-025 With all slots invalid, the outputs SHALL be pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, pipe_hold=0, unless mem_busy or branch_taken is asserted.
REQ-026 Reset asserted mid-stall or mid-freeze SHALL discard every in-flight slot immediately, without waiting for a clock edge.

Configuration
REQ-027 With macro HAZARD_CTL_FORWARDING_EN defined, a hazard SHALL be raised only when the EX slot matches and EX.mem_read=1 (load-use), giving exactly 1 stall cycle.
REQ-028 Without HAZARD_CTL_FORWARDING_EN, a hazard SHALL be raised when the EX or MEM slot matches, stalling until the writer reaches WB; the register file writes before it reads, so WB never matches.

Verification
REQ-029 Scenario: FORWARDING_EN defined; ld x5 followed by add x6,x5,x1 -> 1 cycle with pc_write=0 and id_ex_bubble=1, then RUN; stall_cnt=1.
REQ-030 Scenario: FORWARDING_EN undefined; add x5 followed by sub x7,x5,x2 -> 2 STALL cycles; stall_cnt=2; the sub issues on the 3rd cycle.
REQ-031 Scenario: branch_taken=1 in the same cycle as a load-use hazard -> if_id_flush=1, id_ex_bubble=1, pc_write=1; stall_cnt is unchanged.
REQ-032 Scenario: mem_busy=1 for 3 cycles during a pending stall -> pipe_hold=1 for 3 cycles, the scoreboard is frozen and stall_cnt is unchanged; the stall resumes afterwards.
REQ-033 Scenario: rd=x0 load followed by a use of x0 -> no stall.
REQ-034 Scenario: stall_cnt preloaded to 0xFFFE by forcing, then 3 stall cycles -> stall_cnt=0xFFFF; reset mid-stall -> outputs as in REQ-025 in the same cycle.
